// File: rtl/usb_transmitter_pkg.sv
// Shared USB full-speed definitions for the transmit path (and the receive
// side in usb_controller): PID codes, CRC16 constants, line encodings, FSM
// state type and the serial CRC16 step.
package usb_transmitter_pkg;

  typedef enum logic [3:0] {
    PID_RSVD  = 4'h0, PID_OUT   = 4'h1, PID_ACK   = 4'h2, PID_DATA0 = 4'h3,
    PID_PING  = 4'h4, PID_SOF   = 4'h5, PID_NYET  = 4'h6, PID_DATA2 = 4'h7,
    PID_SPLIT = 4'h8, PID_IN    = 4'h9, PID_NAK   = 4'hA, PID_DATA1 = 4'hB,
    PID_PRE   = 4'hC, PID_SETUP = 4'hD, PID_STALL = 4'hE, PID_MDATA = 4'hF
  } pid_t;

  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // {dp, dn} for full-speed signalling
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_ABORT, S_EOP
  } tx_state_t;

  // DATA0/1/2/MDATA all share the low bits 2'b11
  function automatic logic is_data_pid(input logic [3:0] p);
    return p[1:0] == 2'b11;
  endfunction

  // One payload bit into the CRC16; bit 15 holds the x^15 coefficient
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_transmitter_if.sv
// Request/byte-stream/bus bundle of the USB transmitter.
//   master: requester (start, pid, len0, data, data_valid, data_last)
//   slave : transmitter (data_ready, busy, underrun, dp, dn, oe)
interface usb_transmitter_if;
  logic       start;
  logic [3:0] pid;
  logic       len0;
  logic [7:0] data;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  logic       busy;
  logic       underrun;
  logic       dp;
  logic       dn;
  logic       oe;

  modport master (
    output start, pid, len0, data, data_valid, data_last,
    input  data_ready, busy, underrun, dp, dn, oe
  );

  modport slave (
    input  start, pid, len0, data, data_valid, data_last,
    output data_ready, busy, underrun, dp, dn, oe
  );
endinterface

// File: rtl/usb_transmitter_nrzi_stuffer.sv
// NRZI encoder with bit stuffing and line overrides.
//   bit_en    : advance one bit slot this cycle
//   sync_init : restart encoder at J and clear the ones run (first SYNC bit)
//   bit_val   : data bit for the slot
//   stuff_dis : bit is sent but neither counted nor stuffed (abort pattern)
//   se0/drive_j/line_off : EOP SE0, EOP J, and return to idle (oe=0)
//   stuff_req : a stuffed 0 occupies the next slot; the caller holds its bit
//   dp/dn/oe  : registered bus drive
module usb_transmitter_nrzi_stuffer
  import usb_transmitter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic bit_en,
  input  logic sync_init,
  input  logic bit_val,
  input  logic stuff_dis,
  input  logic se0,
  input  logic drive_j,
  input  logic line_off,
  output logic stuff_req,
  output logic dp,
  output logic dn,
  output logic oe
);

  logic       lvl_j;     // current NRZI level, 1 = J
  logic [2:0] ones;
  logic [1:0] line;
  logic       oe_r;
  logic       cur_lvl, nxt_lvl;
  logic [2:0] cur_ones, nxt_ones;

  assign stuff_req = (ones == 3'd6);

  always_comb begin
    cur_lvl  = sync_init ? 1'b1 : lvl_j;
    cur_ones = sync_init ? 3'd0 : ones;
    if (cur_ones == 3'd6 || !bit_val) begin
      nxt_lvl  = ~cur_lvl;
      nxt_ones = 3'd0;
    end else begin
      nxt_lvl  = cur_lvl;
      nxt_ones = stuff_dis ? 3'd0 : cur_ones + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_j <= 1'b1;
      ones  <= 3'd0;
      line  <= LINE_J;
      oe_r  <= 1'b0;
    end else if (bit_en) begin
      if (line_off) begin
        lvl_j <= 1'b1;
        ones  <= 3'd0;
        line  <= LINE_J;
        oe_r  <= 1'b0;
      end else if (se0) begin
        ones  <= 3'd0;
        line  <= LINE_SE0;
        oe_r  <= 1'b1;
      end else if (drive_j) begin
        lvl_j <= 1'b1;
        ones  <= 3'd0;
        line  <= LINE_J;
        oe_r  <= 1'b1;
      end else begin
        lvl_j <= nxt_lvl;
        ones  <= nxt_ones;
        line  <= nxt_lvl ? LINE_J : LINE_K;
        oe_r  <= 1'b1;
      end
    end
  end

  assign dp = line[1];
  assign dn = line[0];
  assign oe = oe_r;

endmodule

// File: rtl/usb_transmitter.sv
// Full-speed USB transmitter: SYNC, PID, optional payload with CRC16 and EOP,
// NRZI-encoded and bit-stuffed, one bit every CLKS_PER_BIT clocks.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : request, byte stream and line drive (slave modport)
// State/idx always name the next bit to put on the line; each bit slot is
// committed to the encoder on the accepting start edge or on a strobe.
module usb_transmitter
  import usb_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  usb_transmitter_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t        state;
  logic [3:0]       idx;
  logic [CNT_W-1:0] clk_cnt;
  logic [15:0]      crc;
  logic             underrun_r;
  logic [7:0]       pid_byte, shreg;
  logic             len0_r, last_r;

  logic strobe, accept, adv, load_slot, stuff_req;
  logic bit_en, bit_val, stuff_dis, sync_init, se0, drive_j, line_off;
  logic dp_w, dn_w, oe_w;

  assign strobe    = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign accept    = (state == S_IDLE) && bus.start;
  assign adv       = strobe && (state != S_IDLE);
  // a pending stuffed bit takes the slot, so the byte load waits a bit
  assign load_slot = adv && !stuff_req && (state == S_DATA) && (idx == 4'd0);

  always_comb begin
    bit_en    = 1'b0;
    bit_val   = 1'b1;
    stuff_dis = 1'b0;
    sync_init = 1'b0;
    se0       = 1'b0;
    drive_j   = 1'b0;
    line_off  = 1'b0;
    if (accept) begin
      bit_en    = 1'b1;
      bit_val   = 1'b0;
      sync_init = 1'b1;
    end else if (adv) begin
      bit_en = 1'b1;
      if (!stuff_req) begin
        case (state)
          S_SYNC: bit_val = (idx == 4'd7);
          S_PID:  bit_val = pid_byte[idx[2:0]];
          S_DATA: begin
            if (idx != 4'd0)        bit_val = shreg[idx[2:0]];
            else if (bus.data_valid) bit_val = bus.data[0];
            else begin
              bit_val   = 1'b1;
              stuff_dis = 1'b1;
            end
          end
          S_CRC:  bit_val = ~crc[4'd15 - idx];
          S_ABORT: begin
            bit_val   = 1'b1;
            stuff_dis = 1'b1;
          end
          S_EOP: begin
            se0      = (idx < 4'd2);
            drive_j  = (idx == 4'd2);
            line_off = (idx == 4'd3);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 4'd0;
      clk_cnt    <= '0;
      crc        <= CRC16_INIT;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= 1'b0;
      if (accept || strobe) clk_cnt <= '0;
      else                  clk_cnt <= clk_cnt + 1'b1;
      if (accept) begin
        state <= S_SYNC;
        idx   <= 4'd1;
        crc   <= CRC16_INIT;
      end else if (adv && !stuff_req) begin
        case (state)
          S_SYNC: begin
            idx <= (idx == 4'd7) ? 4'd0 : idx + 4'd1;
            if (idx == 4'd7) state <= S_PID;
          end
          S_PID: begin
            idx <= (idx == 4'd7) ? 4'd0 : idx + 4'd1;
            if (idx == 4'd7) begin
              if (!is_data_pid(pid_byte[3:0])) state <= S_EOP;
              else if (len0_r)                 state <= S_CRC;
              else                             state <= S_DATA;
            end
          end
          S_DATA: begin
            if (idx == 4'd0) begin
              idx <= 4'd1;
              if (bus.data_valid) crc <= crc16_step(crc, bus.data[0]);
              else begin
                // this slot already carries the first abort bit
                underrun_r <= 1'b1;
                state      <= S_ABORT;
              end
            end else begin
              crc <= crc16_step(crc, shreg[idx[2:0]]);
              idx <= (idx == 4'd7) ? 4'd0 : idx + 4'd1;
              if (idx == 4'd7 && last_r) state <= S_CRC;
            end
          end
          S_CRC: begin
            idx <= (idx == 4'd15) ? 4'd0 : idx + 4'd1;
            if (idx == 4'd15) state <= S_EOP;
          end
          S_ABORT: begin
            idx <= (idx == 4'd6) ? 4'd0 : idx + 4'd1;
            if (idx == 4'd6) state <= S_EOP;
          end
          S_EOP: begin
            idx <= (idx == 4'd3) ? 4'd0 : idx + 4'd1;
            if (idx == 4'd3) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pid_byte <= {~bus.pid, bus.pid};
      len0_r   <= bus.len0;
    end
    if (load_slot && bus.data_valid) begin
      shreg  <= bus.data;
      last_r <= bus.data_last;
    end
  end

  usb_transmitter_nrzi_stuffer u_nrzi (
    .clk       (clk),
    .reset     (reset),
    .bit_en    (bit_en),
    .sync_init (sync_init),
    .bit_val   (bit_val),
    .stuff_dis (stuff_dis),
    .se0       (se0),
    .drive_j   (drive_j),
    .line_off  (line_off),
    .stuff_req (stuff_req),
    .dp        (dp_w),
    .dn        (dn_w),
    .oe        (oe_w)
  );

  assign bus.data_ready = load_slot;
  assign bus.busy       = (state != S_IDLE);
  assign bus.underrun   = underrun_r;
  assign bus.dp         = dp_w;
  assign bus.dn         = dn_w;
  assign bus.oe         = oe_w;

endmodule

// File: tb/tb_usb_transmitter.sv
// Directed bench for usb_transmitter: line patterns are captured per clock,
// folded to one symbol per bit (J, K, or 0 for SE0) and compared with
// hand-derived strings; a small NRZI/destuff receiver checks payload and CRC.
module tb_usb_transmitter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  usb_transmitter_if bus ();

  usb_transmitter #(.CLKS_PER_BIT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  pay [0:3];
  int          pay_n, pay_i;
  logic        pay_last_en;
  string       line_s;
  logic [1:0]  syms [$];
  int          oe_clks, rdy_cnt, xfer_cnt, unr_cnt, hold_err, timeout;
  logic        busy_first, busy_end;
  bit          dec_bits [$];
  int          dec_stuffs, dec_err;
  logic [15:0] pv;

  localparam string SYNC_S = "KJKJKJKK";
  localparam string ACK_S  = {SYNC_S, "JJKJJKKK", "00J"};
  localparam string D0Z_S  = {SYNC_S, "KKJKJKKK", "JKJKJKJKJKJKJKJK", "00J"};
  localparam string UND_S  = {SYNC_S, "KKJKJKKK", "KJKJKJKJ", "JJJJJJJ", "00J"};
  localparam string D1H_S  = {SYNC_S, "KKJJKJJK", "KKKKKKJJJJJJJKKKKK"};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: got %s, expected %s", tag, obs, exp);
    end
  endtask

  function automatic string sym_ch(input logic [1:0] s);
    case (s)
      2'b10:   return "J";
      2'b01:   return "K";
      2'b00:   return "0";
      default: return "X";
    endcase
  endfunction

  task automatic drive_data();
    if (pay_i < pay_n) begin
      bus.data       = pay[pay_i];
      bus.data_valid = 1'b1;
      bus.data_last  = pay_last_en && (pay_i == pay_n - 1);
    end else begin
      bus.data       = 8'h00;
      bus.data_valid = 1'b0;
      bus.data_last  = 1'b0;
    end
  endtask

  // Issue one request and record the line until oe drops (bounded)
  task automatic run_packet(input logic [3:0] p, input logic l0, input int dup_at);
    bit took;
    syms.delete();
    oe_clks = 0; rdy_cnt = 0; xfer_cnt = 0; unr_cnt = 0; hold_err = 0;
    pay_i = 0;
    took  = 0;
    drive_data();
    @(negedge clk);
    bus.start = 1'b1; bus.pid = p; bus.len0 = l0;
    @(negedge clk);
    bus.start  = 1'b0;
    busy_first = bus.busy;
    for (int c = 0; c < 4000; c++) begin
      if (!bus.oe) break;
      bus.start = (c == dup_at);
      bus.pid   = (c == dup_at) ? 4'h3 : p;
      syms.push_back({bus.dp, bus.dn});
      oe_clks++;
      if (bus.data_ready) rdy_cnt++;
      if (bus.data_ready && bus.data_valid) begin
        xfer_cnt++;
        took = 1;
      end
      if (bus.underrun) unr_cnt++;
      @(negedge clk);
      if (took) begin
        pay_i++;
        drive_data();
        took = 0;
      end
    end
    bus.start = 1'b0;
    bus.pid   = p;
    timeout   = bus.oe ? 1 : 0;
    busy_end  = bus.busy;
    line_s    = "";
    for (int i = 0; i + 1 < syms.size(); i += 2) begin
      if (syms[i] != syms[i+1]) hold_err++;
      line_s = {line_s, sym_ch(syms[i])};
    end
    if (syms.size() % 2 != 0) hold_err++;
  endtask

  // NRZI decode and destuff up to the first SE0
  task automatic decode();
    byte prev, c;
    int  ones;
    bit  d;
    dec_bits.delete();
    dec_stuffs = 0; dec_err = 0; ones = 0;
    prev = "J";
    for (int i = 0; i < line_s.len(); i++) begin
      c = line_s[i];
      if (c == "0") break;
      d    = (c == prev);
      prev = c;
      if (ones == 6) begin
        if (d) dec_err++;
        else   dec_stuffs++;
        ones = 0;
      end else begin
        dec_bits.push_back(d);
        ones = d ? ones + 1 : 0;
      end
    end
  endtask

  function automatic logic [15:0] rx_crc(input int from);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int i = from; i < dec_bits.size(); i++) begin
      fb = r[15] ^ dec_bits[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h8005;
    end
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.pid = 4'h0; bus.len0 = 1'b0;
    bus.data = 8'h00; bus.data_valid = 1'b0; bus.data_last = 1'b0;
    pay_n = 0; pay_i = 0; pay_last_en = 1'b0;
    for (int i = 0; i < 4; i++) pay[i] = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_oe",       32'(bus.oe),         32'd0);
    chk("rst_dp",       32'(bus.dp),         32'd1);
    chk("rst_dn",       32'(bus.dn),         32'd0);
    chk("rst_ready",    32'(bus.data_ready), 32'd0);
    chk("rst_busy",     32'(bus.busy),       32'd0);
    chk("rst_underrun", 32'(bus.underrun),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // ACK handshake
    run_packet(4'h2, 1'b0, -1);
    chk_s("ack_line", line_s, ACK_S);
    chk("ack_oe_clks",   32'(oe_clks),    32'd38);
    chk("ack_hold",      32'(hold_err),   32'd0);
    chk("ack_busy_rise", 32'(busy_first), 32'd1);
    chk("ack_busy_fall", 32'(busy_end),   32'd0);
    chk("ack_ready",     32'(rdy_cnt),    32'd0);
    chk("ack_timeout",   32'(timeout),    32'd0);

    // zero-length DATA0: bytes are offered but must not be taken
    pay[0] = 8'hA5; pay[1] = 8'h5A; pay_n = 2; pay_last_en = 1'b1;
    run_packet(4'h3, 1'b1, -1);
    chk_s("d0z_line", line_s, D0Z_S);
    chk("d0z_oe_clks", 32'(oe_clks), 32'd70);
    chk("d0z_ready",   32'(rdy_cnt), 32'd0);
    decode();
    chk("d0z_bits",     32'(dec_bits.size()), 32'd32);
    chk("d0z_residual", 32'(rx_crc(16)),      32'h800D);

    // DATA1 0xFF,0xFF exercises stuffing inside the payload
    pay[0] = 8'hFF; pay[1] = 8'hFF; pay_n = 2; pay_last_en = 1'b1;
    run_packet(4'hB, 1'b0, -1);
    chk_s("d1_head", line_s.substr(0, 33), D1H_S);
    chk_s("d1_eop",  line_s.substr(line_s.len() - 3, line_s.len() - 1), "00J");
    chk("d1_ready",  32'(rdy_cnt),  32'd2);
    chk("d1_xfer",   32'(xfer_cnt), 32'd2);
    chk("d1_hold",   32'(hold_err), 32'd0);
    decode();
    chk("d1_bits",      32'(dec_bits.size()),  32'd48);
    chk("d1_stuff_err", 32'(dec_err),          32'd0);
    chk("d1_stuffs_ge2", 32'(dec_stuffs >= 2), 32'd1);
    pv = 16'h0000;
    if (dec_bits.size() >= 32)
      for (int i = 0; i < 16; i++) pv[i] = dec_bits[16+i];
    chk("d1_payload",  32'(pv),          32'hFFFF);
    chk("d1_residual", 32'(rx_crc(16)),  32'h800D);
    chk("d1_oe_clks",  32'(oe_clks),     32'(2 * (51 + dec_stuffs)));

    // DATA0 with one byte, then the stream runs dry
    pay[0] = 8'h01; pay_n = 1; pay_last_en = 1'b0;
    run_packet(4'h3, 1'b0, -1);
    chk_s("und_line", line_s, UND_S);
    chk("und_pulses",    32'(unr_cnt),  32'd1);
    chk("und_xfer",      32'(xfer_cnt), 32'd1);
    chk("und_ready",     32'(rdy_cnt),  32'd2);
    chk("und_oe_clks",   32'(oe_clks),  32'd68);
    chk("und_busy_fall", 32'(busy_end), 32'd0);

    // reset while the CRC field of a zero-length DATA0 is on the line
    pay_n = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.pid = 4'h3; bus.len0 = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_oe_before", 32'(bus.oe), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_oe",   32'(bus.oe),   32'd0);
    chk("mid_rst_dp",   32'(bus.dp),   32'd1);
    chk("mid_rst_dn",   32'(bus.dn),   32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    run_packet(4'h2, 1'b0, -1);
    chk_s("post_rst_ack", line_s, ACK_S);
    chk("post_rst_oe_clks", 32'(oe_clks), 32'd38);

    // second start (with a DATA PID) while busy is ignored
    run_packet(4'h2, 1'b0, 10);
    chk_s("dup_ack", line_s, ACK_S);
    chk("dup_oe_clks", 32'(oe_clks), 32'd38);
    @(negedge clk);
    chk("dup_idle_busy", 32'(bus.busy), 32'd0);
    chk("dup_idle_oe",   32'(bus.oe),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_transmitter.md
# usb_transmitter

Full-speed USB serial interface engine, transmit side. It accepts a PID and an optional byte stream, then drives the bus. Output is SYNC, PID, payload, CRC16 and EOP, NRZI-encoded and bit-stuffed, at 12 Mbit/s from the 24 MHz system clock. It is the outbound companion of `usb_controller` and sends handshakes and DATA packets in response to decoded tokens.

## Interface
- Parameters:
  - `CLKS_PER_BIT`, default 2: system clocks per USB bit (24 MHz / 12 Mbit/s).
- Ports:
  - `clk`  in  1  system clock, 24 MHz.
  - `reset`  in  1  synchronous, active-high system reset.
  - `start`  in  1  one-cycle request; sampled only in IDLE.
  - `pid`  in  4  PID code, sampled with `start`; PID byte is sent as {~pid,pid}.
  - `len0`  in  1  sampled with `start`; for DATA PIDs, send zero-length payload.
  - `data`  in  8  payload byte.
  - `data_valid`  in  1  `data` holds a valid byte.
  - `data_last`  in  1  qualifies the final payload byte.
  - `data_ready`  out  1  byte accepted this cycle (transfer = `data_valid & data_ready`).
  - `busy`  out  1  high from the cycle after an accepted `start` through the end of EOP.
  - `underrun`  out  1  one-cycle pulse when a payload byte was needed but `data_valid` was low.
  - `dp`, `dn`  out  1 each  bus drive levels.
  - `oe`  out  1  output enable for the transceiver.

## Operation
- Bit timing:
  - Bit-enable strobe every `CLKS_PER_BIT` clocks.
  - Strobe counter is cleared on accepted `start`.
  - Each state transition happens on a strobe.
- Packet kind, decided by `pid`:
  - DATA0/DATA1/DATA2/MDATA: payload plus CRC16.
  - Any other PID: PID only. `len0` and the data port are ignored.
- States and transitions:
  - IDLE: `oe`=0, line J (`dp`=1, `dn`=0). Accepted `start` → SYNC.
  - SYNC: 8 bits 00000001, LSB first (KJKJKJKK). → PID.
  - PID: 8 bits, LSB first. Then EOP for a non-DATA PID; CRC if DATA and `len0`; otherwise DATA.
  - DATA: a byte is loaded at the strobe starting its bit 0, with `data_ready`=1 for that one cycle.
    - If `data_valid`=0 at that strobe: pulse `underrun`, go to ABORT.
    - After the last bit of a byte accepted with `data_last`: → CRC.
  - CRC: 16 bits of the complemented CRC16 remainder, x^15 coefficient first. → EOP.
    - Polynomial x^16+x^15+x^2+1, initialised to all-ones, computed over payload bits only.
  - ABORT: 7 consecutive line-holding bits with stuffing suppressed (bit-stuff violation). → EOP.
  - EOP: SE0 (`dp`=`dn`=0) for 2 bits, J for 1 bit, then `oe`=0 and IDLE.
- NRZI:
  - Data 0 toggles the line, data 1 holds it.
  - Encoder starts at J at the beginning of SYNC.
- Bit stuffing:
  - Applies to SYNC through CRC.
  - After six consecutive 1s, insert one 0 (a toggle) before the next data bit. The inserted bit consumes a bit slot.
  - Stuff counter resets on any 0 and at SYNC start.
  - No stuffing in EOP.
  - A stuffed bit pending at the end of CRC is still sent before EOP.
- `data_ready` asserts only in DATA, and only on a byte-load strobe. It is never asserted while a stuffed bit is being sent.
- `start` while `busy` is ignored with no side effects.

## Timing
- Reset values: `oe`=0, `dp`=1, `dn`=0, `data_ready`=0, `busy`=0, `underrun`=0; state IDLE, CRC all-ones.
- Reset mid-packet: outputs take reset values the next cycle; no EOP is sent.
- `oe` rises, with the first SYNC bit (K) driven, in the cycle after accepted `start`.
- Each bit holds for exactly `CLKS_PER_BIT` clocks.
- Packet lengths:
  - Handshake packet: 19 bit times (38 clocks) from `oe` rising to `oe` falling.
  - Zero-length DATA packet: 35 bit times plus any stuffed bits.
- `busy` falls in the same cycle `oe` falls. A new `start` is accepted in that cycle.

## Structure
- Shared package `types`: `pid_t` (moved from `usb_controller` so both sides use one definition), CRC16 polynomial and residual constants, full-speed J/K/SE0 line encodings.
- One sub-module: `usb_nrzi_stuffer` (bit in with valid, stuff-request back-pressure, NRZI line state out, EOP/SE0 override).
- The top-level holds the FSM, byte shifter and CRC16.

## Test plan
- `start`, `pid`=ACK (0x2):
  - PID bits 0,1,0,0,1,0,1,1 after KJKJKJKK.
  - SE0 2 bits, J 1 bit; `oe` high exactly 38 clocks.
- DATA0 with `len0`=1: CRC field is sixteen 0 bits (eight full K/J toggle pairs); `data_ready` never asserts.
- DATA1, payload 0xFF,0xFF (`data_last` on second):
  - A stuffed toggle appears after every six held bits.
  - `data_ready` pulses exactly twice.
  - A receiver model decodes the CRC field and checks it against the CRC16 residual.
- DATA0, first byte 0x01 then `data_valid` low at the second byte strobe: `underrun` pulses once, 7 held bits, then EOP; `busy` clears.
- `reset` asserted during the CRC state: next cycle `oe`=0, `dp`=1, `dn`=0. A following ACK request is sent correctly.
- Second `start` pulsed while `busy`: ignored, and the transmitted packet is bit-identical to the single-request case.
